// File: rtl/wbm_cmd_initiator.sv
// Wishbone classic single-cycle master: one command in, one bus cycle, one response out.
// Optional WBM_ERR_EN adds a wbm_err_i termination input (err wins over ack).
module wbm_cmd_initiator #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADR_W   = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
`ifdef WBM_ERR_EN
    input  logic             wbm_err_i,
`endif
    output logic             busy_o
);

    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } req_t;

    state_t           state_q,     state_d;
    req_t             req_q,       req_d;
    logic             cyc_q,       cyc_d;
    logic             stb_q,       stb_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic             rsp_err_q,   rsp_err_d;
    logic             busy_q,      busy_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             bus_err_c;
    logic             timeout_hit_c;

`ifdef WBM_ERR_EN
    assign bus_err_c = wbm_err_i;
`else
    assign bus_err_c = 1'b0;
`endif

    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State and all registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    req_d.we  = cmd_we_i;
                    req_d.adr = cmd_adr_i;
                    req_d.dat = cmd_dat_i;
                    req_d.sel = cmd_sel_i;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_err_c || wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    req_d.we    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err_c;
                    rsp_dat_d   = (bus_err_c || req_q.we) ? '0 : wbm_dat_i;
                    state_d     = ST_RESP;
                end else if (timeout_hit_c) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    req_d.we    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // late or spurious ack is ignored here
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = req_q.we;
    assign wbm_sel_o   = req_q.sel;
    assign wbm_adr_o   = req_q.adr;
    assign wbm_dat_o   = req_q.dat;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_wbm_cmd_initiator.sv
// Scoreboard bench for wbm_cmd_initiator: random commands, modelled slave, queued expectations.
module tb_wbm_cmd_initiator;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack, err, busy;

    always #5 clk = ~clk;

    wbm_cmd_initiator #(.TIMEOUT(TO), .ADR_W(32)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
`ifdef WBM_ERR_EN
        .wbm_err_i(err),
`endif
        .busy_o(busy)
    );

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          wt;
        logic [31:0] rd;
        bit          err;
        logic [31:0] exp_dat;
        bit          exp_err;
        int          exp_stb;
    } txn_t;

    txn_t q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   rdy_mode = 0;
    int   stb_seen = 0;
    bit   stb_prev = 0;
    bit   valid_prev = 0;
    int   cyc_n = 0;
    int   last_acc = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc_n++;

    // Response sink, monitor/scoreboard and wishbone slave model, all on the falling edge
    always @(negedge clk) begin
        case (rdy_mode)
            1:       rsp_ready = 1'b1;
            2:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 2) == 0);
        endcase

        if (rst_n) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("rsp_dat", 64'(rsp_dat), 64'(q[0].exp_dat));
                    chk("rsp_err", 64'(rsp_err), 64'(q[0].exp_err));
                    chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                    chk("busy_in_resp", 64'(busy), 64'd1);
                    if (!valid_prev) chk("stb_cycles", 64'(stb_seen), 64'(q[0].exp_stb));
                    if (rsp_ready) void'(q.pop_front());
                end
            end
            if (stb) begin
                if (!stb_prev) stb_seen = 0;
                stb_seen++;
                if (q.size() == 0) begin
                    chk("stb_without_cmd", 64'(stb), 64'd0);
                end else begin
                    chk("bus_adr", 64'(adr), 64'(q[0].adr));
                    chk("bus_we", 64'(we), 64'(q[0].we));
                    chk("bus_dat", 64'(dat_o), 64'(q[0].dat));
                    chk("bus_sel", 64'(sel), 64'(q[0].sel));
                    chk("bus_cyc", 64'(cyc), 64'd1);
                    chk("busy_in_bus", 64'(busy), 64'd1);
                end
            end
        end
        stb_prev   = stb;
        valid_prev = rsp_valid;

        if (stb && q.size() > 0) begin
            ack   = ((stb_seen - 1) == q[0].wt);
            err   = ack && q[0].err;
            dat_i = q[0].rd;
        end else begin
            ack   = ($urandom_range(0, 2) == 0);
            err   = 1'b0;
            dat_i = $urandom;
        end
    end

    // Queue the expected outcome, then present the command until accepted
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int wt, input logic [31:0] rd, input bit e);
        txn_t t;
        int   n;
        bit   acked;
`ifndef WBM_ERR_EN
        e = 1'b0;
`endif
        acked     = (wt < int'(TO));
        t.we      = w;
        t.adr     = a;
        t.dat     = d;
        t.sel     = s;
        t.wt      = wt;
        t.rd      = rd;
        t.err     = e;
        t.exp_err = !acked || e;
        t.exp_dat = (acked && !e && !w) ? rd : 32'd0;
        t.exp_stb = acked ? wt + 1 : int'(TO);
        q.push_back(t);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("cmd_accept_timeout", 64'(n), 64'd0);
        last_acc = cyc_n;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int a0;
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        dat_i     = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 64'(cyc), 64'd0);
        chk("rst_stb", 64'(stb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_adr", 64'(adr), 64'd0);
        chk("rst_rsp_dat", 64'(rsp_dat), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // write with two wait states, then zero-wait reads back to back
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'hAAAA_5555, 1'b0);
        drain();
        rdy_mode = 1;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3, 0, 32'h1234_5678, 1'b0);
        a0 = last_acc;
        issue(1'b0, 32'h3000_0014, 32'h0, 4'hC, 0, 32'h8765_4321, 1'b0);
        chk("throughput_3cyc", 64'(last_acc - a0), 64'd3);
        drain();
        rdy_mode = 0;

        // timeout, then ack exactly on the last permitted strobe cycle
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF, 40, 32'h5A5A_5A5A, 1'b0);
        issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, int'(TO) - 1, 32'h0BAD_F00D, 1'b0);
        drain();

        // backpressure held for five cycles with spurious acks
        rdy_mode = 2;
        issue(1'b0, 32'h3000_0030, 32'h0, 4'h1, 1, 32'hCAFE_0001, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        drain();
        @(negedge clk);
        chk("bp_idle_busy", 64'(busy), 64'd0);
        chk("bp_idle_ready", 64'(cmd_ready), 64'd1);
        rdy_mode = 0;

        // reset while the strobe is up
        issue(1'b1, 32'h3000_0040, 32'h1111_2222, 4'hF, 30, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_stb", 64'(stb), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cyc", 64'(cyc), 64'd0);
        chk("mid_rst_stb", 64'(stb), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        q.delete();
        repeat (3) @(negedge clk);
        issue(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h3333_4444, 1'b0);
        drain();

`ifdef WBM_ERR_EN
        issue(1'b0, 32'h3000_0050, 32'h0, 4'hF, 1, 32'h7777_8888, 1'b1);
        drain();
`endif

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            rdy_mode = int'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, TO + 3)), $urandom, ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
        $fatal(1);
    end

endmodule

// File: doc/wbm_cmd_initiator.md
Name: wbm_cmd_initiator

Overview:
Wishbone classic single-cycle master for the user area. It accepts one command at a time (address, data, write enable, byte selects) on a valid/ready port and runs one Wishbone read or write. It returns the read data, or an error flag, on a valid/ready response port. It is the initiator end of the wishbone slave interface the user project exposes, and lets internal engines (test sequencers, DMA, FSIC config paths) drive wishbone slaves inside the user area.

Parameters:
TIMEOUT, 255, cycles with stb high and no termination before abort; 0 disables timeout; legal range 0..65535
ADR_W, 32, address width

Ports:
wb_clk_i  input  1  single clock
wb_rst_n_i  input  1  synchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_we_i  input  1  1=write, 0=read
cmd_adr_i  input  ADR_W  byte address
cmd_dat_i  input  32  write data
cmd_sel_i  input  4  byte selects
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_dat_o  output  32  read data; 0 for writes and errors
rsp_err_o  output  1  1=timeout or bus error
wbm_cyc_o  output  1  wishbone cycle
wbm_stb_o  output  1  wishbone strobe
wbm_we_o  output  1  wishbone write enable
wbm_sel_o  output  4  wishbone byte selects
wbm_adr_o  output  ADR_W  wishbone address
wbm_dat_o  output  32  wishbone write data
wbm_dat_i  input  32  wishbone read data
wbm_ack_i  input  1  wishbone acknowledge
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clocking: all state and outputs are registered on the rising edge of wb_clk_i.
- Reset: wb_rst_n_i=0 sampled at an edge forces IDLE and clears the outputs at that edge:
  - cyc, stb, we, rsp_valid, rsp_err, busy = 0
  - adr, dat_o, sel, rsp_dat = 0
  - timeout counter = 0
  - cmd_ready_o = 1 from the first cycle after reset.
- Reset mid-operation: the bus cycle is abandoned, no response is issued, and cyc/stb are low after that edge.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1 (combinational from state only, never from cmd_valid_i).
  - On cmd_valid_i&cmd_ready_o: latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, clear the counter, go to BUS.
  - wbm_ack_i is ignored in IDLE.
- BUS:
  - cmd_ready_o=0; all wbm_* outputs held stable.
  - On wbm_ack_i=1:
    - next edge: cyc=stb=0, we=0
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write
    - rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - Otherwise the counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack in that cycle:
    - next edge: cyc=stb=0, rsp_dat_o=0, rsp_err_o=1, rsp_valid_o=1, go to RESP.
  - Ack and the timeout threshold in the same cycle: ack wins (normal completion).
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held until rsp_ready_i=1.
  - At that handshake edge: rsp_valid_o=0, go to IDLE.
  - Late or spurious wbm_ack_i is ignored.
- Latency:
  - command accepted at edge N → stb high in cycle N+1
  - ack sampled at edge M → rsp_valid high from M+1
  - zero-wait slave with rsp_ready tied high: one transaction every 3 cycles.
- Outstanding transactions: at most one; no pipelining, no bursts (cti/bte are not driven).
- Timeout counter: width $clog2(TIMEOUT+1), minimum 1; saturates, never wraps.

Optional Feature:
WBM_ERR_EN
- Defined:
  - Adds input port wbm_err_i (1 bit).
  - In BUS, wbm_err_i=1 terminates the cycle exactly like ack, but sets rsp_err_o=1 and rsp_dat_o=0.
  - ack and err in the same cycle: err wins.
- Undefined:
  - Port wbm_err_i is absent.
  - Only ack and the timeout terminate a cycle.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF; slave acks after 2 wait states → wbm_* hold those values for 3 cycles, cyc/stb drop the edge after ack, rsp_valid=1, rsp_dat=0, rsp_err=0.
- Read: cmd we=0, adr=0x3000_0010, sel=0x3; zero-wait ack with wbm_dat_i=0x1234_5678 → stb high exactly 1 cycle, rsp_dat=0x1234_5678; with rsp_ready tied high, the next cmd_ready is high 3 cycles after the first accept.
- Timeout: TIMEOUT=8, slave never acks → stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0; an ack in the 8th stb cycle instead → normal completion, rsp_err=0.
- Backpressure: rsp_ready held low 5 cycles after the response → rsp_valid/dat/err stable for all 5 cycles, cmd_ready=0 throughout, extra ack pulses ignored; a single handshake returns the block to IDLE.
- Reset mid-BUS: assert wb_rst_n_i=0 for 1 cycle while stb=1 → cyc/stb=0 and busy=0 after that edge, no rsp_valid ever issued, a following command completes normally.
- WBM_ERR_EN: slave drives err=1 with ack=1 on a read → rsp_err=1, rsp_dat=0.
